// File: rtl/l1_metadata_client_pkg.sv
// Shared types and defaults for the L1 tag/metadata array client.
// Contents: request op encoding, FSM state encoding, invalid coherence
// state value and default geometry (8 ways, 64 sets, 21-bit tag, 2-bit state).
package l1_metadata_client_pkg;

    localparam int N_WAYS_DEF   = 8;
    localparam int IDX_BITS_DEF = 6;
    localparam int TAG_BITS_DEF = 21;
    localparam int COH_BITS_DEF = 2;

    // Coherence state value meaning "way holds nothing"
    localparam int COH_INVALID  = 0;

    // Encoding 3 is reserved and folded into OP_LOOKUP at request capture
    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_ALLOC  = 2'd1,
        OP_INVAL  = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_WRITE,
        S_RESP
    } state_e;

endpackage

// File: rtl/l1_plru_tree.sv
// Combinational tree-PLRU helper for one cache set.
// Node numbering is heap order: node 0 is the root, children of node n are
// 2n+1 (left, lower ways) and 2n+2 (right, higher ways). A bit of 0 steers
// the victim search left, so an all-zero set of bits selects way 0.
// Ports:
//   bits       current PLRU bits of the set
//   touch_way  way being used this access
//   victim     way the current bits point at
//   next_bits  bits after steering every node on touch_way's path away from it
module l1_plru_tree #(
    parameter int   N_WAYS   = 8,
    localparam int  WAY_BITS = $clog2(N_WAYS)
) (
    input  logic [N_WAYS-2:0]   bits,
    input  logic [WAY_BITS-1:0] touch_way,
    output logic [WAY_BITS-1:0] victim,
    output logic [N_WAYS-2:0]   next_bits
);

    always_comb begin
        logic [WAY_BITS-1:0] node;
        victim = '0;
        node   = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            victim = WAY_BITS'({victim, bits[node]});
            node   = WAY_BITS'(2 * node + 1 + bits[node]);
        end
    end

    always_comb begin
        logic [WAY_BITS-1:0] node;
        logic [WAY_BITS-1:0] path;
        logic                dir;
        next_bits = bits;
        node      = '0;
        path      = touch_way;
        for (int l = 0; l < WAY_BITS; l++) begin
            dir             = path[WAY_BITS-1];
            path            = path << 1;
            next_bits[node] = ~dir;
            node            = WAY_BITS'(2 * node + 1 + dir);
        end
    end

endmodule

// File: rtl/l1_metadata_client.sv
// Initiator-side controller for the L1 data-cache tag/metadata array.
// Takes one lookup/alloc/inval request at a time, reads the set, does the
// tag compare and victim choice (first invalid way, else tree-PLRU), writes
// the metadata back when the op changes it, and returns one response.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   req_*                        request handshake and payload
//   meta_read_*                  set read to the array
//   meta_resp_coh/tag            per-way array data, valid the cycle after the read fires
//   meta_write_*                 one-way metadata write
//   resp_*                       response handshake and result
module l1_metadata_client
    import l1_metadata_client_pkg::*;
#(
    parameter int  N_WAYS   = N_WAYS_DEF,
    parameter int  IDX_BITS = IDX_BITS_DEF,
    parameter int  TAG_BITS = TAG_BITS_DEF,
    parameter int  COH_BITS = COH_BITS_DEF,
    localparam int WAY_BITS = $clog2(N_WAYS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [IDX_BITS-1:0]          req_idx,
    input  logic [TAG_BITS-1:0]          req_tag,
    input  logic [COH_BITS-1:0]          req_coh,
    output logic                         meta_read_valid,
    input  logic                         meta_read_ready,
    output logic [IDX_BITS-1:0]          meta_read_idx,
    input  logic [N_WAYS*COH_BITS-1:0]   meta_resp_coh,
    input  logic [N_WAYS*TAG_BITS-1:0]   meta_resp_tag,
    output logic                         meta_write_valid,
    input  logic                         meta_write_ready,
    output logic [IDX_BITS-1:0]          meta_write_idx,
    output logic [N_WAYS-1:0]            meta_write_way_en,
    output logic [COH_BITS-1:0]          meta_write_coh,
    output logic [TAG_BITS-1:0]          meta_write_tag,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp_hit,
    output logic [WAY_BITS-1:0]          resp_way,
    output logic [COH_BITS-1:0]          resp_old_coh,
    output logic [TAG_BITS-1:0]          resp_old_tag
);

    state_e               state, state_next;
    op_e                  op_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic [TAG_BITS-1:0]  tag_q;
    logic [COH_BITS-1:0]  coh_q;
    logic [N_WAYS-2:0]    plru_mem [2**IDX_BITS];

    logic [COH_BITS-1:0]  way_coh [N_WAYS];
    logic [TAG_BITS-1:0]  way_tag [N_WAYS];
    logic [N_WAYS-1:0]    hit_vec, inv_vec;
    logic [WAY_BITS-1:0]  hit_way, first_inv, plru_victim, victim, sel_way;
    logic                 any_hit, need_write, plru_touch;
    logic [N_WAYS-2:0]    plru_next;

    // Tag compare and victim choice; only meaningful while in S_CMP
    always_comb begin
        hit_way   = '0;
        first_inv = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            way_coh[w] = meta_resp_coh[w*COH_BITS +: COH_BITS];
            way_tag[w] = meta_resp_tag[w*TAG_BITS +: TAG_BITS];
            inv_vec[w] = (way_coh[w] == COH_BITS'(COH_INVALID));
            hit_vec[w] = (way_tag[w] == tag_q) && !inv_vec[w];
        end
        // Downward scan so the lowest matching index wins
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way   = WAY_BITS'(w);
            if (inv_vec[w]) first_inv = WAY_BITS'(w);
        end
        any_hit    = |hit_vec;
        victim     = (|inv_vec) ? first_inv : plru_victim;
        sel_way    = any_hit ? hit_way : victim;
        need_write = (op_q == OP_ALLOC) || (op_q == OP_INVAL && any_hit);
        // ALLOC always touches (hit way or victim); LOOKUP only on hit
        plru_touch = (op_q == OP_ALLOC) || (op_q == OP_LOOKUP && any_hit);
    end

    l1_plru_tree #(.N_WAYS(N_WAYS)) u_plru (
        .bits      (plru_mem[idx_q]),
        .touch_way (sel_way),
        .victim    (plru_victim),
        .next_bits (plru_next)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Valids are masked by reset so nothing handshakes in the reset cycle
    always_comb begin
        state_next       = state;
        req_ready        = 1'b0;
        meta_read_valid  = 1'b0;
        meta_write_valid = 1'b0;
        resp_valid       = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !reset;
                if (req_valid) state_next = S_READ;
            end
            S_READ: begin
                meta_read_valid = !reset;
                if (meta_read_ready) state_next = S_CMP;
            end
            S_CMP:   state_next = need_write ? S_WRITE : S_RESP;
            S_WRITE: begin
                meta_write_valid = !reset;
                if (meta_write_ready) state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = !reset;
                if (resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q              <= OP_LOOKUP;
            idx_q             <= '0;
            tag_q             <= '0;
            coh_q             <= '0;
            resp_hit          <= 1'b0;
            resp_way          <= '0;
            resp_old_coh      <= '0;
            resp_old_tag      <= '0;
            meta_write_way_en <= '0;
            meta_write_coh    <= '0;
            meta_write_tag    <= '0;
            for (int s = 0; s < 2**IDX_BITS; s++) plru_mem[s] <= '0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                case (req_op)
                    2'd1:    op_q <= OP_ALLOC;
                    2'd2:    op_q <= OP_INVAL;
                    default: op_q <= OP_LOOKUP;
                endcase
                idx_q <= req_idx;
                tag_q <= req_tag;
                coh_q <= req_coh;
            end
            // Array data exists only this cycle, so everything derived from
            // it is captured here
            if (state == S_CMP) begin
                resp_hit          <= any_hit;
                resp_way          <= sel_way;
                resp_old_coh      <= way_coh[sel_way];
                resp_old_tag      <= way_tag[sel_way];
                meta_write_way_en <= N_WAYS'(1) << sel_way;
                meta_write_coh    <= (op_q == OP_INVAL) ? COH_BITS'(COH_INVALID) : coh_q;
                meta_write_tag    <= any_hit ? way_tag[sel_way] : tag_q;
                if (plru_touch) plru_mem[idx_q] <= plru_next;
            end
        end
    end

    assign meta_read_idx  = idx_q;
    assign meta_write_idx = idx_q;

endmodule
